clmul_seq: RTL

Sequential carry-less (GF(2)[x]) polynomial multiplier. It takes two field elements of up to DATA_WIDTH bits and produces their unreduced 2*DATA_WIDTH-bit product, one multiplier bit per cycle, MSB first. It is the producing end of the reduction datapath: `out` feeds the reducer's `reduc_in` directly, and both blocks use the same `op_enable`/`op_finish` level handshake and `polyn_grade` convention.

---
 rtl/clmul_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/clmul_seq.sv
// clmul_seq -- sequential carry-less (GF(2)[x]) polynomial multiplier.
//
// Produces the unreduced 2*DATA_WIDTH-bit product of two field elements,
// consuming one multiplier bit per cycle, MSB first. The result feeds the
// reducer directly and shares its op_enable/op_finish level handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   op_enable    level request: start in IDLE, hold until op_finish, drop to release
//   polyn_grade  field degree m (clamped to DATA_WIDTH); operand bits >= m are ignored
//   a_in, b_in   multiplicand / multiplier, sampled only on the start edge
//   out          registered product, updated only on completion (or cleared by reset)
//   op_finish    registered result-valid, high in DONE
module clmul_seq #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          op_enable,
  input  logic [$clog2(DATA_WIDTH):0]   polyn_grade,
  input  logic [DATA_WIDTH-1:0]         a_in,
  input  logic [DATA_WIDTH-1:0]         b_in,
  output logic [2*DATA_WIDTH-1:0]       out,
  output logic                          op_finish
);

  localparam int GW = $clog2(DATA_WIDTH) + 1;
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Operands captured at start. b is pre-aligned so the current multiplier
  // bit always sits at the MSB, which keeps the datapath free of a variable
  // bit select.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } opnd_t;

  state_t                state, state_n;
  opnd_t                 opnd, opnd_n;
  logic [PW-1:0]         acc, acc_n, acc_step;
  logic [GW-1:0]         cnt, cnt_n;
  logic [PW-1:0]         out_n;
  logic                  fin_n;

  logic [GW-1:0]         m_eff;
  logic [DATA_WIDTH-1:0] op_mask;

  assign m_eff = (polyn_grade > GW'(DATA_WIDTH)) ? GW'(DATA_WIDTH) : polyn_grade;

  // Keep only operand bits below the effective degree.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mask
    assign op_mask[i] = (GW'(i) < m_eff);
  end

  always_comb begin
    state_n  = state;
    opnd_n   = opnd;
    acc_n    = acc;
    cnt_n    = cnt;
    out_n    = out;
    fin_n    = op_finish;
    acc_step = (acc << 1) ^ (opnd.b[DATA_WIDTH-1] ? {{DATA_WIDTH{1'b0}}, opnd.a} : '0);

    case (state)
      IDLE: begin
        if (op_enable) begin
          state_n = RUN;
          opnd_n.a = a_in & op_mask;
          // Shift bit m_eff-1 up to the MSB; m_eff = 0 shifts everything out.
          opnd_n.b = (b_in & op_mask) << (GW'(DATA_WIDTH) - m_eff);
          acc_n   = '0;
          cnt_n   = m_eff;
        end
      end
      RUN: begin
        if (!op_enable) begin
          // Abort: leave out/op_finish untouched.
          state_n = IDLE;
        end else if (cnt == '0) begin
          // Degenerate m_eff = 0: empty product after a single edge.
          out_n   = '0;
          fin_n   = 1'b1;
          state_n = DONE;
        end else begin
          acc_n    = acc_step;
          opnd_n.b = opnd.b << 1;
          cnt_n    = cnt - 1'b1;
          if (cnt == GW'(1)) begin
            out_n   = acc_step;
            fin_n   = 1'b1;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        if (!op_enable) begin
          state_n = IDLE;
          fin_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      opnd      <= '0;
      acc       <= '0;
      cnt       <= '0;
      out       <= '0;
      op_finish <= 1'b0;
    end else begin
      state     <= state_n;
      opnd      <= opnd_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      out       <= out_n;
      op_finish <= fin_n;
    end
  end

endmodule
